// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the IM address,
// buffers fetched words in a 2-entry queue toward decode, applies redirects.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   im_pc / im_instr / im_adel   IM address out, combinational data/AdEL in
//   exc_req, eret_req/epc, br_req/br_target   redirect requests (priority order)
//   id_valid/id_ready, id_instr/id_pc/id_adel   decode handshake and head entry
//   fetch_halted            fetch stopped after an AdEL, awaiting a redirect
module im_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    input  logic        im_adel,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        br_req,
    input  logic [31:0] br_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_adel,
    output logic        fetch_halted
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t      st;
    logic [31:0] pc;
    logic [31:0] q_instr [2];
    logic [31:0] q_pc    [2];
    logic        q_adel  [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        deq;
    logic        enq;
    logic        redir;
    logic [31:0] redir_pc;

    assign im_pc        = pc;
    assign id_valid     = (count != 2'd0);
    assign id_instr     = q_instr[rd_ptr];
    assign id_pc        = q_pc[rd_ptr];
    assign id_adel      = q_adel[rd_ptr];
    assign fetch_halted = (st == HALT);

    assign deq   = id_valid & id_ready;
    assign redir = exc_req | eret_req | br_req;
    // A redirect cycle never enqueues: the word at im_pc is on the dead path.
    assign enq   = (st == FETCH) & ((count < 2'd2) | deq) & ~redir;

    always_comb begin
        redir_pc = br_target;
        if (exc_req)
            redir_pc = EXC_ENTRY;
        else if (eret_req)
            redir_pc = epc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= FETCH;
            pc         <= RESET_PC;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            q_instr[0] <= 32'h0;
            q_instr[1] <= 32'h0;
            q_pc[0]    <= 32'h0;
            q_pc[1]    <= 32'h0;
            q_adel[0]  <= 1'b0;
            q_adel[1]  <= 1'b0;
        end else if (redir) begin
            st     <= FETCH;
            pc     <= redir_pc;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (enq) begin
                q_instr[wr_ptr] <= im_adel ? 32'h0 : im_instr;
                q_pc[wr_ptr]    <= pc;
                q_adel[wr_ptr]  <= im_adel;
                wr_ptr          <= ~wr_ptr;
                // The faulting PC is held so it stays visible until redirect.
                if (im_adel)
                    st <= HALT;
                else
                    pc <= pc + 32'd4;
            end
            if (deq)
                rd_ptr <= ~rd_ptr;
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed testbench for im_fetch_ctrl with a behavioural IM that returns
// 0xAAAA_0000+PC and flags misaligned or out-of-range addresses.
module tb_im_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] im_pc;
    logic [31:0] im_instr;
    logic        im_adel;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        br_req;
    logic [31:0] br_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_adel;
    logic        fetch_halted;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign im_instr = 32'hAAAA_0000 + im_pc;
    assign im_adel  = (im_pc[1:0] != 2'b00) ||
                      (im_pc < 32'h0000_3000) ||
                      (im_pc > 32'h0000_6ffc);

    im_fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .im_pc        (im_pc),
        .im_instr     (im_instr),
        .im_adel      (im_adel),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .br_req       (br_req),
        .br_target    (br_target),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_adel      (id_adel),
        .fetch_halted (fetch_halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"},  {31'b0, id_valid},     32'd0);
        chk({tag, "_instr"},  id_instr,              32'h0);
        chk({tag, "_idpc"},   id_pc,                 32'h0);
        chk({tag, "_adel"},   {31'b0, id_adel},      32'd0);
        chk({tag, "_halted"}, {31'b0, fetch_halted}, 32'd0);
        chk({tag, "_impc"},   im_pc,                 32'h3000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        exc_req   = 1'b0;
        eret_req  = 1'b0;
        epc       = 32'h0;
        br_req    = 1'b0;
        br_target = 32'h0;
        id_ready  = 1'b0;
        step();
        step();
        chk_reset("rst0");

        // streaming with decode always ready
        reset    = 1'b0;
        id_ready = 1'b1;
        step();
        chk("s0_pc",    id_pc,               32'h3000);
        chk("s0_valid", {31'b0, id_valid},   32'd1);
        chk("s0_instr", id_instr,            32'hAAAA_3000);
        step();
        chk("s1_pc",    id_pc,               32'h3004);
        chk("s1_valid", {31'b0, id_valid},   32'd1);
        step();
        chk("s2_pc",    id_pc,               32'h3008);
        chk("s2_valid", {31'b0, id_valid},   32'd1);

        // reset mid-stream
        reset = 1'b1;
        step();
        chk_reset("rst1");

        // backpressure: queue fills, PC freezes
        reset    = 1'b0;
        id_ready = 1'b0;
        repeat (5) step();
        chk("bp_impc",  im_pc,             32'h3008);
        chk("bp_idpc",  id_pc,             32'h3000);
        chk("bp_valid", {31'b0, id_valid}, 32'd1);
        id_ready = 1'b1;
        step();
        chk("rel0_pc", id_pc, 32'h3004);
        step();
        chk("rel1_pc", id_pc, 32'h3008);
        chk("rel1_impc", im_pc, 32'h3010);

        // branch while queue is full
        id_ready  = 1'b0;
        br_req    = 1'b1;
        br_target = 32'h3100;
        step();
        chk("br_valid", {31'b0, id_valid}, 32'd0);
        chk("br_impc",  im_pc,             32'h3100);
        br_req = 1'b0;
        step();
        chk("br_idpc",  id_pc,             32'h3100);
        chk("br_valid2", {31'b0, id_valid}, 32'd1);

        // misaligned target -> AdEL entry and halt
        br_req    = 1'b1;
        br_target = 32'h3102;
        step();
        chk("mis_impc", im_pc, 32'h3102);
        br_req = 1'b0;
        step();
        chk("mis_adel",   {31'b0, id_adel},      32'd1);
        chk("mis_instr",  id_instr,              32'h0);
        chk("mis_idpc",   id_pc,                 32'h3102);
        chk("mis_halted", {31'b0, fetch_halted}, 32'd1);
        step();
        chk("mis_hold",   im_pc,                 32'h3102);
        chk("mis_valid",  {31'b0, id_valid},     32'd1);
        exc_req = 1'b1;
        step();
        chk("exc_impc",   im_pc,                 32'h4180);
        chk("exc_halted", {31'b0, fetch_halted}, 32'd0);
        chk("exc_valid",  {31'b0, id_valid},     32'd0);

        // redirect priority
        eret_req  = 1'b1;
        epc       = 32'h3040;
        br_req    = 1'b1;
        br_target = 32'h3200;
        step();
        chk("prio_impc", im_pc, 32'h4180);
        exc_req = 1'b0;
        br_req  = 1'b0;
        step();
        chk("eret_impc", im_pc, 32'h3040);
        eret_req = 1'b0;

        // top of the legal range
        id_ready  = 1'b1;
        br_req    = 1'b1;
        br_target = 32'h6ff8;
        step();
        chk("top_impc0", im_pc, 32'h6ff8);
        br_req = 1'b0;
        step();
        chk("top_idpc0", id_pc, 32'h6ff8);
        chk("top_impc1", im_pc, 32'h6ffc);
        step();
        chk("top_idpc1", id_pc,            32'h6ffc);
        chk("top_adel1", {31'b0, id_adel}, 32'd0);
        chk("top_instr1", id_instr,        32'hAAAA_6ffc);
        chk("top_impc2", im_pc,            32'h7000);
        step();
        chk("top_idpc2",  id_pc,                 32'h7000);
        chk("top_adel2",  {31'b0, id_adel},      32'd1);
        chk("top_instr2", id_instr,              32'h0);
        chk("top_halted", {31'b0, fetch_halted}, 32'd1);
        step();
        chk("halt_valid", {31'b0, id_valid},     32'd0);
        chk("halt_hold",  im_pc,                 32'h7000);
        chk("halt_still", {31'b0, fetch_halted}, 32'd1);

        // reset while halted
        reset = 1'b1;
        step();
        chk_reset("rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/im_fetch_ctrl.md
# im_fetch_ctrl

Instruction-fetch sequencer sitting between the PC logic of the pipelined CPU and the combinational instruction memory. It owns the fetch PC and drives the IM word address every cycle. It buffers fetched words, each tagged with its PC and AdEL flag, in a 2-entry queue feeding decode over a valid/ready handshake, and it applies redirects from exception entry, `eret` and branch/jump resolution.

## Interface
- `RESET_PC`, 32'h0000_3000, fetch PC after reset
- `EXC_ENTRY`, 32'h0000_4180, exception handler entry PC
- `clk` input 1: sole clock, rising edge
- `reset` input 1: synchronous, active-high; all state cleared on the edge where it is sampled high
- `im_pc` output 32: address presented to IM (= fetch PC register)
- `im_instr` input 32: IM read data for `im_pc`, combinational, same cycle
- `im_adel` input 1: IM flags `im_pc` misaligned or outside 0x3000–0x6ffc
- `exc_req` input 1: redirect to `EXC_ENTRY`
- `eret_req` input 1: redirect to `epc`
- `epc` input 32: return PC for `eret_req`
- `br_req` input 1: redirect to `br_target`
- `br_target` input 32: branch/jump target
- `id_valid` output 1: queue head holds a valid entry
- `id_ready` input 1: decode accepts head this cycle
- `id_instr` output 32: head instruction (32'h0 when head AdEL)
- `id_pc` output 32: head PC
- `id_adel` output 1: head entry carries AdEL
- `fetch_halted` output 1: FSM in HALT

## Operation
- Storage: 2-entry circular queue (`instr`, `pc`, `adel` per entry), 1-bit read/write pointers, 2-bit `count` (0..2). Head outputs driven from registered entries; `id_valid = (count != 0)`.
- Dequeue: `deq = id_valid & id_ready`.
- FSM states FETCH, HALT.
  - FETCH: `enq = (count < 2) | deq`. On `enq`, write {`im_instr`, `im_pc`, `im_adel`} at tail; if `im_adel`, store instr 32'h0, do not advance the PC, go to HALT; else PC <= PC + 4 (32-bit wrap, no carry out).
  - HALT: no enqueue, PC held; remains until a redirect. Entries already queued still drain normally.
- Redirect priority, evaluated each cycle: `reset` > `exc_req` > `eret_req` > `br_req`. The winner loads PC (`EXC_ENTRY` / `epc` / `br_target`), flushes the queue (count <= 0, pointers <= 0), forces FSM to FETCH, and suppresses enqueue that cycle. A `deq` in the same cycle is still a legal handshake; the entry is consumed and the flush discards the rest.
- Redirect target is not checked here; a bad target surfaces as `im_adel` on the next fetch.
- Full with no `deq`: enqueue and PC both stall; `im_pc` stable.

## Timing
- Reset values: PC = `RESET_PC`, `count` = 0, pointers = 0, FSM = FETCH, `id_valid` = 0, `id_instr` = 0, `id_pc` = 0, `id_adel` = 0, `fetch_halted` = 0.
- Fetch-to-decode latency: a word presented on `im_pc` in cycle N is visible at `id_*` in cycle N+1 if the queue was empty.
- Redirect asserted in cycle N: `im_pc` = target in N+1, first target word at `id_*` in N+2, `id_valid` = 0 in N+1.
- Steady state with `id_ready` held high: one instruction per cycle and no bubbles.
- Simultaneous `exc_req` and `br_req`: PC takes `EXC_ENTRY`.
- `reset` mid-stream or in HALT: next cycle matches the reset values exactly.

## Test plan
- Reset, then `id_ready`=1, IM returning 0xAAAA_0000+PC: `id_pc` = 0x3000, 0x3004, 0x3008 on consecutive cycles starting the cycle after reset deasserts, `id_valid` continuous.
- `id_ready`=0 for 5 cycles: `count` saturates at 2, `im_pc` frozen at 0x3008, `id_pc` held at 0x3000. Then release: 0x3000, 0x3004, 0x3008 with no loss or duplication.
- `br_req`=1 with `br_target`=0x3100 while the queue is full: next cycle `id_valid`=0 and `im_pc`=0x3100; the cycle after, `id_pc`=0x3100.
- `br_target`=0x3102, so IM asserts `im_adel`: entry presented with `id_adel`=1, `id_instr`=0, `id_pc`=0x3102; `fetch_halted`=1 and `im_pc` held. `exc_req` then gives `im_pc`=0x4180 and `fetch_halted`=0.
- `exc_req`, `eret_req` (`epc`=0x3040) and `br_req` asserted together: `im_pc`=0x4180. Next cycle `eret_req` alone: `im_pc`=0x3040.
- PC reaches 0x6ffc with sequential fetch: 0x6ffc is delivered normally; 0x7000 returns `im_adel`=1 and the FSM halts.
